// File: rtl/eth_type_demux_if.sv
// Ethernet frame channel bundle: header handshake plus AXI-stream payload.
// Valid/ready vectors are NCH wide so one type serves the 1-lane input and the M-lane output.
// Header fields and payload data are shared by all lanes; only the handshakes are per lane.
interface eth_type_demux_if #(
  parameter int NCH        = 1,
  parameter int DATA_WIDTH = 8,
  parameter int USER_WIDTH = 1
);
  logic [NCH-1:0]        hdr_valid;
  logic [NCH-1:0]        hdr_ready;
  logic [47:0]           dest_mac;
  logic [47:0]           src_mac;
  logic [15:0]           eth_type;
  logic [DATA_WIDTH-1:0] tdata;
  logic [NCH-1:0]        tvalid;
  logic [NCH-1:0]        tready;
  logic                  tlast;
  logic [USER_WIDTH-1:0] tuser;

  modport master (
    output hdr_valid, dest_mac, src_mac, eth_type, tdata, tvalid, tlast, tuser,
    input  hdr_ready, tready
  );

  modport slave (
    input  hdr_valid, dest_mac, src_mac, eth_type, tdata, tvalid, tlast, tuser,
    output hdr_ready, tready
  );
endinterface

// File: rtl/eth_type_demux.sv
// EtherType classifier: routes each frame to the enabled channel matching its type, else drops it.
// Latency: header outputs one cycle after accept; payload passes through combinationally (zero cycles).
// Backpressure: payload ready follows the selected channel; drops sink at full rate; no header while one is pending.
module eth_type_demux #(
  parameter int                    M_COUNT    = 4,
  parameter int                    DATA_WIDTH = 8,
  parameter int                    USER_WIDTH = 1,
  parameter logic [M_COUNT*16-1:0] TYPE_TABLE = {16'h88F7, 16'h86DD, 16'h0806, 16'h0800},
  parameter int                    CNT_WIDTH  = 32
) (
  input  logic                           clk,
  input  logic                           rst_n,
  eth_type_demux_if.slave                s_eth,
  eth_type_demux_if.master               m_eth,
  input  logic [M_COUNT-1:0]             chan_enable,
  input  logic                           stat_clear,
  output logic [M_COUNT*CNT_WIDTH-1:0]   stat_frame_count,
  output logic [CNT_WIDTH-1:0]           stat_drop_count,
  output logic                           busy
);

  localparam int SELW = (M_COUNT > 1) ? $clog2(M_COUNT) : 1;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_FWD,
    ST_DROP
  } state_t;

  state_t                state_q, state_d;
  logic [SELW-1:0]       sel_q, sel_d;
  logic [M_COUNT-1:0]    hdr_vld_q, hdr_vld_d;
  logic [47:0]           dest_q, dest_d;
  logic [47:0]           src_q, src_d;
  logic [15:0]           type_q, type_d;
  logic [CNT_WIDTH-1:0]  frame_cnt_q [M_COUNT];
  logic [CNT_WIDTH-1:0]  frame_cnt_d [M_COUNT];
  logic [CNT_WIDTH-1:0]  drop_cnt_q, drop_cnt_d;

  logic                  match_hit;
  logic [SELW-1:0]       match_sel;
  logic                  hdr_rdy;
  logic                  hdr_acc;
  logic                  pay_rdy;
  logic                  beat_last;
  logic [M_COUNT-1:0]    pay_vld;
  logic [DATA_WIDTH-1:0] pay_dat;
  logic [USER_WIDTH-1:0] pay_usr;

  // Lowest-index enabled channel whose table entry equals the incoming EtherType.
  always_comb begin
    match_hit = 1'b0;
    match_sel = '0;
    for (int i = M_COUNT - 1; i >= 0; i--) begin
      if (chan_enable[i] && (s_eth.eth_type == TYPE_TABLE[16*i +: 16])) begin
        match_hit = 1'b1;
        match_sel = SELW'(i);
      end
    end
  end

  // A pending downstream header blocks the next accept, even after its payload has finished.
  assign hdr_rdy = (state_q == ST_IDLE) && (hdr_vld_q == '0);
  assign hdr_acc = s_eth.hdr_valid[0] && hdr_rdy;

  // Payload steering from the per-frame registered select; idle stalls the input stream.
  always_comb begin
    pay_vld = '0;
    pay_rdy = 1'b0;
    case (state_q)
      ST_FWD: begin
        pay_vld[sel_q] = s_eth.tvalid[0];
        pay_rdy        = m_eth.tready[sel_q];
      end
      ST_DROP: pay_rdy = 1'b1;
      default: ;
    endcase
  end

  assign beat_last = s_eth.tvalid[0] && pay_rdy && s_eth.tlast;
  assign pay_dat   = s_eth.tdata;
  assign pay_usr   = s_eth.tuser;

  assign s_eth.hdr_ready = hdr_rdy;
  assign s_eth.tready    = pay_rdy;
  assign m_eth.hdr_valid = hdr_vld_q;
  assign m_eth.dest_mac  = dest_q;
  assign m_eth.src_mac   = src_q;
  assign m_eth.eth_type  = type_q;
  assign m_eth.tvalid    = pay_vld;
  assign m_eth.tdata     = pay_dat;
  assign m_eth.tlast     = s_eth.tlast;
  assign m_eth.tuser     = pay_usr;

  // Frame state machine next-state: header accept picks FWD or DROP, the last input beat returns to IDLE.
  always_comb begin
    state_d   = state_q;
    sel_d     = sel_q;
    dest_d    = dest_q;
    src_d     = src_q;
    type_d    = type_q;
    hdr_vld_d = hdr_vld_q & ~m_eth.hdr_ready;
    case (state_q)
      ST_IDLE: begin
        if (hdr_acc) begin
          if (match_hit) begin
            state_d              = ST_FWD;
            sel_d                = match_sel;
            dest_d               = s_eth.dest_mac;
            src_d                = s_eth.src_mac;
            type_d               = s_eth.eth_type;
            hdr_vld_d[match_sel] = 1'b1;
          end else begin
            state_d = ST_DROP;
          end
        end
      end
      ST_FWD, ST_DROP: begin
        if (beat_last) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Saturating statistics; a clear wins over a same-cycle increment.
  always_comb begin
    for (int i = 0; i < M_COUNT; i++) begin
      frame_cnt_d[i] = frame_cnt_q[i];
      if (stat_clear) begin
        frame_cnt_d[i] = '0;
      end else if (hdr_acc && match_hit && (match_sel == SELW'(i)) && (frame_cnt_q[i] != '1)) begin
        frame_cnt_d[i] = frame_cnt_q[i] + 1'b1;
      end
    end
    drop_cnt_d = drop_cnt_q;
    if (stat_clear) begin
      drop_cnt_d = '0;
    end else if (hdr_acc && !match_hit && (drop_cnt_q != '1)) begin
      drop_cnt_d = drop_cnt_q + 1'b1;
    end
  end

  // State, header and counter registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= ST_IDLE;
      sel_q      <= '0;
      hdr_vld_q  <= '0;
      dest_q     <= '0;
      src_q      <= '0;
      type_q     <= '0;
      drop_cnt_q <= '0;
      for (int i = 0; i < M_COUNT; i++) frame_cnt_q[i] <= '0;
    end else begin
      state_q    <= state_d;
      sel_q      <= sel_d;
      hdr_vld_q  <= hdr_vld_d;
      dest_q     <= dest_d;
      src_q      <= src_d;
      type_q     <= type_d;
      drop_cnt_q <= drop_cnt_d;
      for (int i = 0; i < M_COUNT; i++) frame_cnt_q[i] <= frame_cnt_d[i];
    end
  end

  for (genvar g = 0; g < M_COUNT; g++) begin : g_stat
    assign stat_frame_count[g*CNT_WIDTH +: CNT_WIDTH] = frame_cnt_q[g];
  end

  assign stat_drop_count = drop_cnt_q;
  assign busy            = (state_q != ST_IDLE);

endmodule
